etc_barrier_array: RTL and testbench
====================================

ETC_BARRIER_ARRAY -- requirements
Module: etc_barrier_array

Interface
REQ-001 Parameter LANES, default 4, number of independent toll lanes (1..16).
REQ-002 Parameter HOLD_CYCLES, default 16, cycles the barrier stays open after a vehicle clears (>=1).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, cycles an open barrier waits for a vehicle before auto-closing (>=2).
REQ-004 Parameter CNT_W, default 16, width of each per-lane pass counter.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 up  input  LANES  per-lane manual open command.
REQ-008 down  input  LANES  per-lane manual close command.
REQ-009 en  input  LANES  per-lane valid-tag open request.
REQ-010 dis  input  LANES  per-lane invalid-tag close request.
REQ-011 veh_present  input  LANES  per-lane vehicle-under-barrier sensor, level, already synchronised.
REQ-012 force_open  input  1  global maintenance/emergency override, level.
REQ-013 clr_count  input  1  synchronous clear of all pass counters.
REQ-014 en_barrier  output  LANES  registered per-lane barrier-open drive, 1 = open.
REQ-015 timeout_evt  output  LANES  registered one-cycle pulse per lane on auto-close by timeout.
REQ-016 pass_count  output  LANES*CNT_W  per-lane vehicle pass counters, lane i in bits [i*CNT_W +: CNT_W].

Function
REQ-017 Each lane SHALL contain an independent FSM: CLOSED, OPEN_WAIT, OCCUPIED, HOLD, plus one timer sized to hold max(HOLD_CYCLES, TIMEOUT_CYCLES)-1.
REQ-018 Per-cycle priority SHALL be: veh_present > (up|en) > (down|dis) > timer expiry.
REQ-019 CLOSED: veh_present -> OCCUPIED; else up|en -> OPEN_WAIT, timer=0; else stay.
REQ-020 OPEN_WAIT: veh_present -> OCCUPIED; else up|en -> stay, timer=0; else down|dis -> CLOSED; else timer==TIMEOUT_CYCLES-1 -> CLOSED with timeout_evt=1 next cycle; else timer+1.
REQ-021 OCCUPIED: veh_present=1 -> stay, all commands ignored (barrier never closes on a vehicle); veh_present=0 -> HOLD, timer=0, pass_count+1.
REQ-022 HOLD: veh_present -> OCCUPIED (no count); else up|en -> OPEN_WAIT, timer=0; else down|dis -> CLOSED; else timer==HOLD_CYCLES-1 -> CLOSED; else timer+1.
REQ-023 en_barrier[i] SHALL be registered as (next state != CLOSED) | force_open, giving one-cycle latency from command to output.
REQ-024 force_open SHALL affect only en_barrier; FSMs, timers and counters SHALL keep running; on force_open deassert en_barrier follows FSM state on the next edge.
REQ-025 pass_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-026 clr_count SHALL zero all counters next edge; an increment in the same cycle SHALL be lost (clear wins).
REQ-027 timeout_evt SHALL pulse exactly one cycle per timeout and be 0 otherwise.
REQ-028 Lanes SHALL not interact except via force_open and clr_count.

Reset
REQ-029 reset=1 SHALL force every FSM to CLOSED, timers to 0, en_barrier=0, timeout_evt=0, pass_count=0 on the next edge, overriding all other inputs including force_open.
REQ-030 Reset asserted mid-operation (any state, vehicle present) SHALL give the REQ-029 values; after release lanes with veh_present=1 enter OCCUPIED next cycle.

Verification
REQ-031 Lane0 en pulse, no vehicle, defaults -> en_barrier[0]=1 one cycle later, stays 1 for 1024 cycles, then 0 with timeout_evt[0] one-cycle pulse.
REQ-032 Lane1 en, veh_present 1 for 5 cycles then 0 -> en_barrier[1] stays 1 throughout plus 16 cycles HOLD, then 0; pass_count lane1=1.
REQ-033 Lane2 in OCCUPIED, down and dis asserted -> en_barrier[2] stays 1; same cycle en+dis in OPEN_WAIT -> stays open.
REQ-034 force_open=1 with all lanes CLOSED -> en_barrier=all ones next cycle; deassert -> all zeros next cycle; no counter change.
REQ-035 CNT_W=2, four passes on lane3 -> pass_count lane3 = 3; clr_count coincident with a pass -> 0.
REQ-036 reset during HOLD with force_open=1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/etc_barrier_array_if.sv
// Toll-lane barrier bus: per-lane commands and sensors in, barrier drive,
// timeout pulses and packed pass counters out.
interface etc_barrier_array_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic [LANES-1:0]       up;
  logic [LANES-1:0]       down;
  logic [LANES-1:0]       en;
  logic [LANES-1:0]       dis;
  logic [LANES-1:0]       veh_present;
  logic                   force_open;
  logic                   clr_count;
  logic [LANES-1:0]       en_barrier;
  logic [LANES-1:0]       timeout_evt;
  logic [LANES*CNT_W-1:0] pass_count;

  modport master (
    output up, down, en, dis, veh_present, force_open, clr_count,
    input  en_barrier, timeout_evt, pass_count
  );

  modport slave (
    input  up, down, en, dis, veh_present, force_open, clr_count,
    output en_barrier, timeout_evt, pass_count
  );
endinterface

// File: rtl/etc_barrier_array.sv
// Array of independent toll-lane barrier controllers; lanes share only the
// global force_open override and the counter clear.
module etc_barrier_lane #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             open_req,
  input  logic             close_req,
  input  logic             veh,
  input  logic             force_open,
  input  logic             clr_count,
  output logic             bar,
  output logic             tevt,
  output logic [CNT_W-1:0] cnt
);
  localparam int MAXT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TONE      = TW'(1);

  typedef enum logic [1:0] {CLOSED, OPEN_WAIT, OCCUPIED, HOLD} state_t;

  state_t        state;
  logic [TW-1:0] tmr;

  // bar is written alongside every state transition so it reflects the
  // next state: any non-CLOSED target drives 1, CLOSED falls back to force_open.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLOSED;
      tmr   <= '0;
      bar   <= 1'b0;
      tevt  <= 1'b0;
      cnt   <= '0;
    end else begin
      tevt <= 1'b0;
      if (clr_count) cnt <= '0;
      case (state)
        CLOSED: begin
          if (veh) begin
            state <= OCCUPIED;
            bar   <= 1'b1;
          end else if (open_req) begin
            state <= OPEN_WAIT;
            tmr   <= '0;
            bar   <= 1'b1;
          end else begin
            bar   <= force_open;
          end
        end
        OPEN_WAIT: begin
          if (veh) begin
            state <= OCCUPIED;
            bar   <= 1'b1;
          end else if (open_req) begin
            tmr   <= '0;
            bar   <= 1'b1;
          end else if (close_req) begin
            state <= CLOSED;
            bar   <= force_open;
          end else if (tmr == TO_LAST) begin
            state <= CLOSED;
            bar   <= force_open;
            tevt  <= 1'b1;
          end else begin
            tmr   <= tmr + TONE;
            bar   <= 1'b1;
          end
        end
        OCCUPIED: begin
          bar <= 1'b1;
          // Commands are ignored while a vehicle is under the barrier.
          if (!veh) begin
            state <= HOLD;
            tmr   <= '0;
            if (!clr_count && cnt != '1) cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (veh) begin
            state <= OCCUPIED;
            bar   <= 1'b1;
          end else if (open_req) begin
            state <= OPEN_WAIT;
            tmr   <= '0;
            bar   <= 1'b1;
          end else if (close_req) begin
            state <= CLOSED;
            bar   <= force_open;
          end else if (tmr == HOLD_LAST) begin
            state <= CLOSED;
            bar   <= force_open;
          end else begin
            tmr   <= tmr + TONE;
            bar   <= 1'b1;
          end
        end
        default: begin
          state <= CLOSED;
          bar   <= force_open;
        end
      endcase
    end
  end
endmodule

module etc_barrier_array #(
  parameter int LANES          = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input logic               clk,
  input logic               reset,
  etc_barrier_array_if.slave bus
);
  logic [LANES-1:0]            bar;
  logic [LANES-1:0]            tevt;
  logic [LANES-1:0][CNT_W-1:0] cnt;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      etc_barrier_lane #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
      ) u_lane (
        .clk       (clk),
        .reset     (reset),
        .open_req  (bus.up[i] | bus.en[i]),
        .close_req (bus.down[i] | bus.dis[i]),
        .veh       (bus.veh_present[i]),
        .force_open(bus.force_open),
        .clr_count (bus.clr_count),
        .bar       (bar[i]),
        .tevt      (tevt[i]),
        .cnt       (cnt[i])
      );
    end
  endgenerate

  assign bus.en_barrier  = bar;
  assign bus.timeout_evt = tevt;
  assign bus.pass_count  = cnt;
endmodule

// File: tb/tb_etc_barrier_array.sv
// Directed plus randomized check of the barrier array against a deadline-based
// reference model; CNT_W is narrowed so counter saturation is reachable.
module tb_etc_barrier_array;
  localparam int LANES = 4;
  localparam int HOLD  = 16;
  localparam int TO    = 1024;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  etc_barrier_array_if #(.LANES(LANES), .CNT_W(CW)) bus ();

  etc_barrier_array #(
    .LANES(LANES), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: lane mode plus the absolute cycle at which an open barrier
  // closes by itself (timeout while waiting, hold expiry after a pass).
  int             mode [LANES];  // 0 closed, 1 waiting for car, 2 car under, 3 holding
  longint         dl   [LANES];
  int             cnt  [LANES];
  logic [LANES-1:0] e_bar, e_tev;
  longint         ncyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic op, cl, v;
    ncyc++;
    e_tev = '0;
    for (int i = 0; i < LANES; i++) begin
      op = bus.up[i] | bus.en[i];
      cl = bus.down[i] | bus.dis[i];
      v  = bus.veh_present[i];
      if (reset) begin
        mode[i] = 0;
        cnt[i]  = 0;
      end else begin
        case (mode[i])
          0: if (v) mode[i] = 2;
             else if (op) begin mode[i] = 1; dl[i] = ncyc + TO; end
          1: if (v) mode[i] = 2;
             else if (op) dl[i] = ncyc + TO;
             else if (cl) mode[i] = 0;
             else if (ncyc == dl[i]) begin mode[i] = 0; e_tev[i] = 1'b1; end
          2: if (!v) begin
               mode[i] = 3;
               dl[i]   = ncyc + HOLD;
               if (cnt[i] < CMAX) cnt[i]++;
             end
          default:
             if (v) mode[i] = 2;
             else if (op) begin mode[i] = 1; dl[i] = ncyc + TO; end
             else if (cl) mode[i] = 0;
             else if (ncyc == dl[i]) mode[i] = 0;
        endcase
        if (bus.clr_count) cnt[i] = 0;
      end
      e_bar[i] = !reset && ((mode[i] != 0) || bus.force_open);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("en_barrier", {28'd0, bus.en_barrier}, {28'd0, e_bar});
    chk("timeout_evt", {28'd0, bus.timeout_evt}, {28'd0, e_tev});
    for (int i = 0; i < LANES; i++)
      chk($sformatf("pass_count[%0d]", i), {30'd0, bus.pass_count[i*CW +: CW]}, cnt[i]);
  endtask

  task automatic idle_inputs();
    bus.up = '0; bus.down = '0; bus.en = '0; bus.dis = '0;
    bus.veh_present = '0; bus.force_open = 1'b0; bus.clr_count = 1'b0;
  endtask

  initial begin
    int open_cyc, tev_seen, hold_cyc;
    idle_inputs();
    reset = 1'b1;
    bus.force_open = 1'b1;
    step();
    step();
    chk("reset_bar", {28'd0, bus.en_barrier}, 32'd0);
    bus.force_open = 1'b0;
    reset = 1'b0;
    step();

    // Lane0: single en pulse, no vehicle, runs into the timeout.
    open_cyc = 0; tev_seen = 0;
    bus.en[0] = 1'b1;
    step();
    if (bus.en_barrier[0]) open_cyc++;
    bus.en[0] = 1'b0;
    for (int k = 0; k < 1100 && bus.en_barrier[0]; k++) begin
      step();
      if (bus.en_barrier[0]) open_cyc++;
      if (bus.timeout_evt[0]) tev_seen++;
    end
    chk("timeout_open_cycles", open_cyc, 1024);
    chk("timeout_pulse_count", tev_seen, 1);
    step();
    chk("timeout_pulse_cleared", {31'd0, bus.timeout_evt[0]}, 32'd0);

    // Lane1: open, vehicle for 5 cycles, then 16-cycle hold.
    bus.en[1] = 1'b1;
    step();
    bus.en[1] = 1'b0;
    bus.veh_present[1] = 1'b1;
    repeat (5) step();
    bus.veh_present[1] = 1'b0;
    hold_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!bus.en_barrier[1]) break;
      hold_cyc++;
    end
    chk("hold_cycles", hold_cyc, 16);
    chk("lane1_passes", {30'd0, bus.pass_count[1*CW +: CW]}, 32'd1);

    // Lane2: close commands ignored with a vehicle; open beats close.
    bus.veh_present[2] = 1'b1;
    step();
    bus.down[2] = 1'b1; bus.dis[2] = 1'b1;
    repeat (3) step();
    chk("occupied_ignores_close", {31'd0, bus.en_barrier[2]}, 32'd1);
    idle_inputs();
    step();
    bus.en[2] = 1'b1;
    step();
    bus.dis[2] = 1'b1;
    repeat (2) step();
    chk("open_beats_close", {31'd0, bus.en_barrier[2]}, 32'd1);
    idle_inputs();
    bus.dis[2] = 1'b1;
    step();
    chk("dis_closes", {31'd0, bus.en_barrier[2]}, 32'd0);
    idle_inputs();

    // force_open with every lane closed.
    bus.force_open = 1'b1;
    step();
    chk("force_all_open", {28'd0, bus.en_barrier}, 32'hF);
    bus.force_open = 1'b0;
    step();
    chk("force_release", {28'd0, bus.en_barrier}, 32'h0);

    // Lane3: saturation at 3, then clear racing an increment.
    for (int p = 0; p < 4; p++) begin
      bus.veh_present[3] = 1'b1; step();
      bus.veh_present[3] = 1'b0; step();
    end
    chk("saturate", {30'd0, bus.pass_count[3*CW +: CW]}, 32'd3);
    bus.clr_count = 1'b1; step();
    bus.clr_count = 1'b0;
    bus.veh_present[3] = 1'b1; step();
    bus.veh_present[3] = 1'b0; bus.clr_count = 1'b1; step();
    chk("clear_wins", {30'd0, bus.pass_count[3*CW +: CW]}, 32'd0);
    idle_inputs();
    repeat (20) step();

    // Reset during HOLD with force_open held, vehicle waiting on lane1.
    bus.veh_present[0] = 1'b1; step();
    bus.veh_present[0] = 1'b0; step();
    bus.force_open = 1'b1; step();
    reset = 1'b1; bus.veh_present[1] = 1'b1;
    step();
    chk("reset_hold_bar", {28'd0, bus.en_barrier}, 32'd0);
    chk("reset_hold_tevt", {28'd0, bus.timeout_evt}, 32'd0);
    chk("reset_hold_cnt", {24'd0, bus.pass_count}, 32'd0);
    reset = 1'b0; bus.force_open = 1'b0;
    step();
    chk("release_occupied", {31'd0, bus.en_barrier[1]}, 32'd1);
    idle_inputs();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < LANES; i++) begin
        bus.up[i]   = ($urandom_range(15) == 0);
        bus.en[i]   = ($urandom_range(15) == 0);
        bus.down[i] = ($urandom_range(15) == 0);
        bus.dis[i]  = ($urandom_range(15) == 0);
        if ($urandom_range(7) == 0) bus.veh_present[i] = ~bus.veh_present[i];
      end
      bus.force_open = ($urandom_range(31) == 0);
      bus.clr_count  = ($urandom_range(63) == 0);
      reset          = ($urandom_range(299) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
